// File: rtl/bridge_test_responder.sv
// Avalon-MM test responder: ID, scratch, free-running cycle, status and LED registers.
// Define BRIDGE_RESP_TXN_COUNT_EN to build the WR_COUNT/RD_COUNT transaction counters.
module bridge_test_responder #(
    parameter logic [31:0] ID_VALUE    = 32'hB51D_0001,
    parameter int unsigned INIT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic [3:0]  avs_byteenable,
    output logic [31:0] avs_readdata,
    output logic        avs_readdatavalid,
    output logic        avs_waitrequest,
    output logic [9:0]  led
);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam logic [3:0]  ADDR_ID      = 4'd0;
    localparam logic [3:0]  ADDR_SCRATCH0 = 4'd1;
    localparam logic [3:0]  ADDR_SCRATCH1 = 4'd2;
    localparam logic [3:0]  ADDR_CYCLE   = 4'd3;
    localparam logic [3:0]  ADDR_WR_CNT  = 4'd4;
    localparam logic [3:0]  ADDR_RD_CNT  = 4'd5;
    localparam logic [3:0]  ADDR_STATUS  = 4'd6;
    localparam logic [3:0]  ADDR_LED     = 4'd7;
    localparam logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF;

    state_t      state_q, state_d;
    logic [31:0] init_cnt_q, init_cnt_d;
    logic [31:0] scratch0_q, scratch0_d;
    logic [31:0] scratch1_q, scratch1_d;
    logic [31:0] cycle_q, cycle_d;
    logic        err_q, err_d;
    logic [9:0]  led_q, led_d;
    logic        rd_v1_q, rd_v1_d;
    logic [31:0] rd_data1_q, rd_data1_d;
    logic        rdv_q, rdv_d;
    logic [31:0] rdata_q, rdata_d;
`ifdef BRIDGE_RESP_TXN_COUNT_EN
    logic [31:0] wr_cnt_q, wr_cnt_d;
    logic [31:0] rd_cnt_q, rd_cnt_d;
`endif

    logic        ready_s;
    logic        rd_acc_s;
    logic        wr_acc_s;
    logic        proto_err_s;
    logic        unmapped_s;
    logic        err_set_s;
    logic        err_clr_s;
    logic [31:0] rd_data_s;

    // Replace only the byte lanes selected by the byte enables.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_v[8*b +: 8];
            end
        end
        return res;
    endfunction

    // Next-state logic: hold waitrequest for INIT_CYCLES cycles, then stay ready.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_INIT: begin
                if ((init_cnt_q + 32'd1) >= INIT_CYCLES) begin
                    state_d = ST_READY;
                end else begin
                    init_cnt_d = init_cnt_q + 32'd1;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d    = ST_INIT;
                init_cnt_d = 32'd0;
            end
        endcase
    end

    assign ready_s     = (state_q == ST_READY);
    assign rd_acc_s    = ready_s & avs_read & ~avs_write;
    assign wr_acc_s    = ready_s & avs_write & ~avs_read;
    assign proto_err_s = ready_s & avs_read & avs_write;
    assign unmapped_s  = avs_address[3];
    assign err_set_s   = proto_err_s | ((rd_acc_s | wr_acc_s) & unmapped_s);
    assign err_clr_s   = wr_acc_s & (avs_address == ADDR_STATUS) & avs_writedata[0];

    // Read mux: register values as they stand in the acceptance cycle.
    always_comb begin
        rd_data_s = 32'd0;
        case (avs_address)
            ADDR_ID:       rd_data_s = ID_VALUE;
            ADDR_SCRATCH0: rd_data_s = scratch0_q;
            ADDR_SCRATCH1: rd_data_s = scratch1_q;
            ADDR_CYCLE:    rd_data_s = cycle_q;
`ifdef BRIDGE_RESP_TXN_COUNT_EN
            ADDR_WR_CNT:   rd_data_s = wr_cnt_q;
            ADDR_RD_CNT:   rd_data_s = rd_cnt_q;
`else
            ADDR_WR_CNT:   rd_data_s = 32'd0;
            ADDR_RD_CNT:   rd_data_s = 32'd0;
`endif
            ADDR_STATUS:   rd_data_s = {31'd0, err_q};
            ADDR_LED:      rd_data_s = {22'd0, led_q};
            default:       rd_data_s = UNMAPPED_DATA;
        endcase
    end

    // Register file next state; a write to CYCLE overrides the increment.
    always_comb begin
        scratch0_d = scratch0_q;
        scratch1_d = scratch1_q;
        led_d      = led_q;
        cycle_d    = cycle_q;
        err_d      = err_q;
        if (ready_s) begin
            cycle_d = cycle_q + 32'd1;
        end else begin
            cycle_d = cycle_q;
        end
        if (wr_acc_s) begin
            case (avs_address)
                ADDR_SCRATCH0: scratch0_d = merge_bytes(scratch0_q, avs_writedata, avs_byteenable);
                ADDR_SCRATCH1: scratch1_d = merge_bytes(scratch1_q, avs_writedata, avs_byteenable);
                ADDR_CYCLE:    cycle_d    = 32'd0;
                ADDR_LED:      led_d      = avs_writedata[9:0];
                default:       led_d      = led_q;
            endcase
        end else begin
            led_d = led_q;
        end
        if (err_set_s) begin
            err_d = 1'b1;
        end else if (err_clr_s) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

`ifdef BRIDGE_RESP_TXN_COUNT_EN
    // Count accepted transactions; protocol errors are never accepted as either.
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (wr_acc_s) begin
            wr_cnt_d = wr_cnt_q + 32'd1;
        end else begin
            wr_cnt_d = wr_cnt_q;
        end
        if (rd_acc_s) begin
            rd_cnt_d = rd_cnt_q + 32'd1;
        end else begin
            rd_cnt_d = rd_cnt_q;
        end
    end
`endif

    // Two-stage read pipeline; data is forced to zero whenever the stage is empty.
    always_comb begin
        rd_v1_d    = rd_acc_s;
        rd_data1_d = rd_acc_s ? rd_data_s : 32'd0;
        rdv_d      = rd_v1_q;
        rdata_d    = rd_v1_q ? rd_data1_q : 32'd0;
    end

    // State and register updates with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_INIT;
            init_cnt_q <= 32'd0;
            scratch0_q <= 32'd0;
            scratch1_q <= 32'd0;
            cycle_q    <= 32'd0;
            err_q      <= 1'b0;
            led_q      <= 10'd0;
            rd_v1_q    <= 1'b0;
            rd_data1_q <= 32'd0;
            rdv_q      <= 1'b0;
            rdata_q    <= 32'd0;
`ifdef BRIDGE_RESP_TXN_COUNT_EN
            wr_cnt_q   <= 32'd0;
            rd_cnt_q   <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            scratch0_q <= scratch0_d;
            scratch1_q <= scratch1_d;
            cycle_q    <= cycle_d;
            err_q      <= err_d;
            led_q      <= led_d;
            rd_v1_q    <= rd_v1_d;
            rd_data1_q <= rd_data1_d;
            rdv_q      <= rdv_d;
            rdata_q    <= rdata_d;
`ifdef BRIDGE_RESP_TXN_COUNT_EN
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
`endif
        end
    end

    assign avs_waitrequest   = (state_q == ST_INIT);
    assign avs_readdatavalid = rdv_q;
    assign avs_readdata      = rdata_q;
    assign led               = led_q;

endmodule

// File: tb/tb_bridge_test_responder.sv
// Self-checking bench for bridge_test_responder: directed literal cases plus a randomized
// run compared every cycle against a transaction-level model of the register map.
module tb_bridge_test_responder;

    localparam int unsigned TB_INIT = 4;
    localparam logic [31:0] ID_EXP  = 32'hB51D_0001;

    logic        clk;
    logic        reset;
    logic [3:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic        avs_waitrequest;
    logic [9:0]  led;

    bridge_test_responder #(
        .ID_VALUE    (ID_EXP),
        .INIT_CYCLES (TB_INIT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_byteenable    (avs_byteenable),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .avs_waitrequest   (avs_waitrequest),
        .led               (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int unsigned due;
        logic [31:0] data;
    } exp_t;

    exp_t        resp_q[$];
    int unsigned tb_cyc = 0;
    bit          m_valid = 1'b0;
    bit          m_ready;
    int unsigned m_left;
    logic [31:0] m_scr0, m_scr1, m_cycle, m_wrc, m_rdc;
    logic        m_err;
    logic [9:0]  m_led;
    bit          rd_ok, wr_ok, both;
    logic [31:0] rv;

    function automatic logic [31:0] model_read(input logic [3:0] a);
        case (a)
            4'd0: return ID_EXP;
            4'd1: return m_scr0;
            4'd2: return m_scr1;
            4'd3: return m_cycle;
`ifdef BRIDGE_RESP_TXN_COUNT_EN
            4'd4: return m_wrc;
            4'd5: return m_rdc;
`else
            4'd4: return 32'd0;
            4'd5: return 32'd0;
`endif
            4'd6: return {31'd0, m_err};
            4'd7: return {22'd0, m_led};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1'b1;
            m_ready = 1'b0;
            m_left  = TB_INIT;
            m_scr0 = 32'd0; m_scr1 = 32'd0; m_cycle = 32'd0;
            m_wrc  = 32'd0; m_rdc  = 32'd0; m_err = 1'b0; m_led = 10'd0;
            resp_q.delete();
        end else if (m_valid) begin
            rd_ok = m_ready && avs_read && !avs_write;
            wr_ok = m_ready && avs_write && !avs_read;
            both  = m_ready && avs_read && avs_write;
            rv    = model_read(avs_address);
            if (rd_ok) resp_q.push_back('{due: tb_cyc + 2, data: rv});
            if (m_ready) m_cycle = m_cycle + 32'd1;
            if (wr_ok) begin
                if (avs_address == 4'd1) m_scr0 = lanes(m_scr0, avs_writedata, avs_byteenable);
                if (avs_address == 4'd2) m_scr1 = lanes(m_scr1, avs_writedata, avs_byteenable);
                if (avs_address == 4'd3) m_cycle = 32'd0;
                if (avs_address == 4'd7) m_led = avs_writedata[9:0];
                if (avs_address == 4'd6 && avs_writedata[0]) m_err = 1'b0;
                m_wrc = m_wrc + 32'd1;
            end
            if (rd_ok) m_rdc = m_rdc + 32'd1;
            if (both || ((rd_ok || wr_ok) && avs_address >= 4'd8)) m_err = 1'b1;
            if (!m_ready) begin
                if (m_left <= 1) m_ready = 1'b1;
                else m_left = m_left - 1;
            end
        end
        tb_cyc++;
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic        e_rv;
        logic [31:0] e_rd;
        if (m_valid) begin
            e_rv = 1'b0;
            e_rd = 32'd0;
            if (resp_q.size() > 0 && resp_q[0].due == tb_cyc) begin
                e_rv = 1'b1;
                e_rd = resp_q[0].data;
                void'(resp_q.pop_front());
            end
            check("m_waitrequest", {31'd0, avs_waitrequest}, {31'd0, !m_ready});
            check("m_readdatavalid", {31'd0, avs_readdatavalid}, {31'd0, e_rv});
            check("m_readdata", avs_readdata, e_rd);
            check("m_led", {22'd0, led}, {22'd0, m_led});
        end
    end

    // ---------------- directed stimulus helpers ----------------
    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d, output int lat);
        @(negedge clk);
        avs_address = a; avs_read = 1'b1;
        d = 32'd0; lat = -1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) avs_read = 1'b0;
            if (avs_readdatavalid) begin
                d = avs_readdata; lat = k;
                break;
            end
        end
    endtask

    logic [31:0] d;
    int          lat;
    logic [3:0]  seq_a [4];
    logic [31:0] seq_e [4];
`ifdef BRIDGE_RESP_TXN_COUNT_EN
    logic [31:0] w0, r0;
`endif

    initial begin
        reset = 1'b1; avs_address = 4'd0; avs_read = 1'b0; avs_write = 1'b0;
        avs_writedata = 32'd0; avs_byteenable = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_waitrequest", {31'd0, avs_waitrequest}, 32'd1);
        check("rst_readdatavalid", {31'd0, avs_readdatavalid}, 32'd0);
        check("rst_readdata", avs_readdata, 32'd0);
        check("rst_led", {22'd0, led}, 32'd0);

        // Release: waitrequest high for 4 cycles, then low.
        reset = 1'b0;
        check("init_wait0", {31'd0, avs_waitrequest}, 32'd1);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check("init_wait", {31'd0, avs_waitrequest}, 32'd1);
        end
        @(negedge clk);
        check("init_ready", {31'd0, avs_waitrequest}, 32'd0);

        rd(4'd0, d, lat);
        check("id_data", d, 32'hB51D_0001);
        check("id_latency", 32'(lat), 32'd2);

        wr(4'd1, 32'h1122_3344, 4'b1111);
        wr(4'd1, 32'hAABB_CCDD, 4'b0101);
        rd(4'd1, d, lat);
        check("scratch0_lanes", d, 32'h11BB_33DD);
        wr(4'd2, 32'hCAFE_F00D, 4'b0000);
        rd(4'd2, d, lat);
        check("scratch1_be0", d, 32'd0);

        wr(4'd7, 32'hFFFF_F2A5, 4'b1111);
        check("led_out", {22'd0, led}, 32'h0000_02A5);

        wr(4'd3, 32'h1234_5678, 4'b1111);
        rd(4'd3, d, lat);
        check("cycle_clear", d, 32'd1);

        // Four back-to-back reads with responses on consecutive cycles.
        seq_a = '{4'd0, 4'd1, 4'd7, 4'd9};
        seq_e = '{32'hB51D_0001, 32'h11BB_33DD, 32'h0000_02A5, 32'hDEAD_BEEF};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                check("b2b_valid", {31'd0, avs_readdatavalid}, 32'd1);
                check("b2b_data", avs_readdata, seq_e[i-2]);
            end
            avs_read = (i < 4);
            if (i < 4) avs_address = seq_a[i];
        end
        rd(4'd6, d, lat);
        check("status_set", d, 32'd1);
        wr(4'd6, 32'd1, 4'b0001);
        rd(4'd6, d, lat);
        check("status_w1c", d, 32'd0);

        // Simultaneous read and write: protocol error.
`ifdef BRIDGE_RESP_TXN_COUNT_EN
        rd(4'd4, w0, lat);
        rd(4'd5, r0, lat);
`endif
        @(negedge clk);
        avs_address = 4'd1; avs_writedata = 32'h0; avs_byteenable = 4'hF;
        avs_read = 1'b1; avs_write = 1'b1;
        @(negedge clk);
        avs_read = 1'b0; avs_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("perr_no_valid", {31'd0, avs_readdatavalid}, 32'd0);
        end
`ifdef BRIDGE_RESP_TXN_COUNT_EN
        rd(4'd4, d, lat);
        check("perr_wrcnt", d, w0);
        rd(4'd5, d, lat);
        check("perr_rdcnt", d, r0 + 32'd2);
`else
        rd(4'd4, d, lat);
        check("wrcnt_absent", d, 32'd0);
`endif
        rd(4'd6, d, lat);
        check("perr_status", d, 32'd1);
        rd(4'd1, d, lat);
        check("perr_scratch0", d, 32'h11BB_33DD);

        // Reset the cycle after a read is accepted.
        @(negedge clk);
        avs_address = 4'd0; avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0; reset = 1'b1;
        @(negedge clk);
        check("rstmid_no_valid", {31'd0, avs_readdatavalid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20 && avs_waitrequest; i++) begin
            @(negedge clk);
            check("rstmid_no_valid_init", {31'd0, avs_readdatavalid}, 32'd0);
        end
        check("rstmid_ready", {31'd0, avs_waitrequest}, 32'd0);
        check("rstmid_led", {22'd0, led}, 32'd0);
        rd(4'd1, d, lat);
        check("rstmid_scratch0", d, 32'd0);

        // Randomized traffic, including occasional resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset          = ($urandom_range(0, 599) == 0);
            avs_read       = ($urandom_range(0, 2) == 0);
            avs_write      = ($urandom_range(0, 2) == 0);
            avs_address    = 4'($urandom_range(0, 15));
            avs_writedata  = $urandom;
            avs_byteenable = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        reset = 1'b0; avs_read = 1'b0; avs_write = 1'b0;
        repeat (8) @(negedge clk);
        check("queue_drained", 32'(resp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
